// File: rtl/switch_game_core.sv
// switch_game_core
// Single-FSM engine for the switch game: picks a pseudo-random switch to
// flip, waits for the switches to settle, scores the result and runs the
// round timer. The HexDisplay drivers render score, high_score and
// time_left outside this block.
//
// Ports
//   clk         system clock
//   reset       synchronous, active-high; restores every register, high_score included
//   start       level; begins a game from IDLE or OVER, ignored during play
//   sw          switch inputs, already synchronised upstream
//   led_prompt  one-hot target during play, all ones in OVER, zero in IDLE
//   score       current game score, saturating
//   high_score  best score since reset
//   time_left   seconds remaining in the round
//   game_over   high while in OVER
//   hit / miss  one-cycle pulses reporting the outcome of each check
module switch_game_core #(
    parameter int NUM_SW        = 10,
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int GAME_SEC      = 20,
    parameter int SETTLE_CYC    = 1_000_000,
    parameter int STREAK_LEN    = 5,
    parameter int SCORE_W       = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [NUM_SW-1:0]  sw,
    output logic [NUM_SW-1:0]  led_prompt,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] high_score,
    output logic [5:0]         time_left,
    output logic               game_over,
    output logic               hit,
    output logic               miss
);

    localparam int SEC_W    = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int SET_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int STREAK_W = $clog2(STREAK_LEN + 1);

    localparam logic [SEC_W-1:0]    SEC_LAST     = SEC_W'(TICKS_PER_SEC - 1);
    localparam logic [SET_W-1:0]    SET_LAST     = SET_W'(SETTLE_CYC - 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX   = STREAK_W'(STREAK_LEN);
    localparam logic [STREAK_W-1:0] STREAK_BONUS = STREAK_W'(STREAK_LEN - 1);
    localparam logic [SCORE_W:0]    SCORE_ONE    = (SCORE_W+1)'(1);
    localparam logic [SCORE_W:0]    SCORE_TWO    = (SCORE_W+1)'(2);
    localparam logic [4:0]          NUM_SW5      = 5'(NUM_SW);
    localparam logic [5:0]          GAME_TIME    = 6'(GAME_SEC);
    localparam logic [15:0]         LFSR_SEED    = 16'hACE1;
    localparam logic [15:0]         LFSR_TAPS    = 16'hB400;

    typedef enum logic [2:0] {
        IDLE,
        PROMPT,
        WAIT,
        SETTLE,
        CHECK,
        OVER
    } state_t;

    state_t              state;
    logic [15:0]         lfsr;
    logic [3:0]          last_idx;
    logic [NUM_SW-1:0]   expected;
    logic [NUM_SW-1:0]   snapshot;
    logic [SEC_W-1:0]    sec_cnt;
    logic [SET_W-1:0]    settle_cnt;
    logic [STREAK_W-1:0] streak;

    logic [15:0]         lfsr_next;
    logic [4:0]          idx_mod;
    logic [4:0]          idx_inc;
    logic [3:0]          idx;
    logic [NUM_SW-1:0]   prompt_bit;
    logic [SCORE_W:0]    score_sum;
    logic [SCORE_W-1:0]  score_next;
    logic [STREAK_W-1:0] streak_next;
    logic                running;
    logic                sec_wrap;
    logic                timeout;

    always_comb begin
        // Galois form, taps 16,14,13,11, shifting toward bit 0
        lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);

        // Never repeat the previous target: bump to the next switch instead
        idx_mod = {1'b0, lfsr[3:0]} % NUM_SW5;
        idx_inc = idx_mod + 5'd1;
        if (idx_mod[3:0] == last_idx)
            idx = (idx_inc == NUM_SW5) ? 4'd0 : idx_inc[3:0];
        else
            idx = idx_mod[3:0];
        prompt_bit = {{(NUM_SW-1){1'b0}}, 1'b1} << idx;

        // The bonus uses the streak before this hit is counted
        score_sum   = {1'b0, score} + ((streak >= STREAK_BONUS) ? SCORE_TWO : SCORE_ONE);
        score_next  = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
        streak_next = (streak >= STREAK_MAX) ? STREAK_MAX : streak + STREAK_W'(1);

        running  = state inside {PROMPT, WAIT, SETTLE, CHECK};
        sec_wrap = (sec_cnt == SEC_LAST);
        timeout  = running && sec_wrap && (time_left == 6'd1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            lfsr       <= LFSR_SEED;
            last_idx   <= '0;
            expected   <= '0;
            snapshot   <= '0;
            sec_cnt    <= '0;
            settle_cnt <= '0;
            streak     <= '0;
            led_prompt <= '0;
            score      <= '0;
            high_score <= '0;
            time_left  <= GAME_TIME;
            game_over  <= 1'b0;
            hit        <= 1'b0;
            miss       <= 1'b0;
        end else begin
            lfsr <= lfsr_next;
            hit  <= 1'b0;
            miss <= 1'b0;

            if (running) begin
                if (sec_wrap) begin
                    sec_cnt   <= '0;
                    time_left <= time_left - 6'd1;
                end else begin
                    sec_cnt <= sec_cnt + SEC_W'(1);
                end
            end

            // Running out of time overrides whatever the FSM was doing,
            // including a check landing in the same cycle
            if (timeout) begin
                state      <= OVER;
                game_over  <= 1'b1;
                led_prompt <= '1;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state      <= PROMPT;
                            score      <= '0;
                            streak     <= '0;
                            time_left  <= GAME_TIME;
                            sec_cnt    <= '0;
                            led_prompt <= '0;
                            game_over  <= 1'b0;
                        end
                    end
                    PROMPT: begin
                        expected   <= sw ^ prompt_bit;
                        snapshot   <= sw;
                        led_prompt <= prompt_bit;
                        last_idx   <= idx;
                        state      <= WAIT;
                    end
                    WAIT: begin
                        if (sw != snapshot) begin
                            snapshot   <= sw;
                            settle_cnt <= '0;
                            state      <= SETTLE;
                        end
                    end
                    SETTLE: begin
                        // Any movement restarts the whole stability window
                        if (sw != snapshot) begin
                            snapshot   <= sw;
                            settle_cnt <= '0;
                        end else if (settle_cnt == SET_LAST) begin
                            state <= CHECK;
                        end else begin
                            settle_cnt <= settle_cnt + SET_W'(1);
                        end
                    end
                    CHECK: begin
                        if (sw == expected) begin
                            hit    <= 1'b1;
                            streak <= streak_next;
                            score  <= score_next;
                        end else begin
                            miss   <= 1'b1;
                            streak <= '0;
                        end
                        state <= PROMPT;
                    end
                    OVER: begin
                        // score is frozen here, so repeating the max is harmless
                        if (score > high_score)
                            high_score <= score;
                        if (start) begin
                            state      <= PROMPT;
                            score      <= '0;
                            streak     <= '0;
                            time_left  <= GAME_TIME;
                            sec_cnt    <= '0;
                            led_prompt <= '0;
                            game_over  <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_switch_game_core.sv
// tb_switch_game_core
// Self-checking bench for switch_game_core. Two instances share clock and
// reset: a short-round one (3 s of 10 ticks) for timing, bounce and
// high-score behaviour, and a long-round one (3 s of 100 ticks) with room
// for enough hits to saturate the 4-bit score. Expected hit/miss outcomes
// and scores are queued when the switches are driven and popped when the
// design reports a check.
module tb_switch_game_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       start0, start1;
    logic [3:0] sw0, sw1;
    logic [3:0] led0, led1, score0, score1, high0, high1;
    logic [5:0] tl0, tl1;
    logic       go0, go1, hit0, hit1, miss0, miss1;

    switch_game_core #(
        .NUM_SW(4), .TICKS_PER_SEC(10), .GAME_SEC(3),
        .SETTLE_CYC(4), .STREAK_LEN(2), .SCORE_W(4)
    ) dut (
        .clk(clk), .reset(reset), .start(start0), .sw(sw0),
        .led_prompt(led0), .score(score0), .high_score(high0),
        .time_left(tl0), .game_over(go0), .hit(hit0), .miss(miss0)
    );

    switch_game_core #(
        .NUM_SW(4), .TICKS_PER_SEC(100), .GAME_SEC(3),
        .SETTLE_CYC(4), .STREAK_LEN(2), .SCORE_W(4)
    ) dut_long (
        .clk(clk), .reset(reset), .start(start1), .sw(sw1),
        .led_prompt(led1), .score(score1), .high_score(high1),
        .time_left(tl1), .game_over(go1), .hit(hit1), .miss(miss1)
    );

    // Instance currently under test
    int         sel;
    logic [3:0] led_m, score_m, high_m;
    logic [5:0] tl_m;
    logic       go_m, hit_m, miss_m;

    always_comb begin
        if (sel == 0) begin
            led_m = led0; score_m = score0; high_m = high0;
            tl_m = tl0; go_m = go0; hit_m = hit0; miss_m = miss0;
        end else begin
            led_m = led1; score_m = score1; high_m = high1;
            tl_m = tl1; go_m = go1; hit_m = hit1; miss_m = miss1;
        end
    end

    // Prompt generator model: both instances share reset, so one copy serves both
    logic [15:0] m_lfsr;
    always @(posedge clk) begin
        if (reset)
            m_lfsr <= 16'hACE1;
        else
            m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       is_hit;
        logic [3:0] score;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [3:0] m_sw [2];
    int         m_last [2];
    logic [3:0] m_led;
    logic [3:0] m_expected;
    int         m_score;
    int         m_streak;
    int         m_high;
    int         gstart;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] v);
        m_sw[sel] = v;
        if (sel == 0) sw0 = v;
        else          sw1 = v;
    endtask

    task automatic setStart(input logic v);
        if (sel == 0) start0 = v;
        else          start1 = v;
    endtask

    // Called in the cycle the design sits in PROMPT
    task automatic predictPrompt();
        int idx;
        idx = int'(m_lfsr[3:0]) % 4;
        if (idx == m_last[sel]) idx = (idx + 1) % 4;
        m_last[sel] = idx;
        m_led       = 4'(1 << idx);
        m_expected  = m_sw[sel] ^ m_led;
    endtask

    task automatic startGame(input string tag);
        gstart = cyc;
        setStart(1'b1);
        m_score  = 0;
        m_streak = 0;
        tick();
        setStart(1'b0);
        predictPrompt();
        tick();
        checkOutput({tag, "_prompt"},    16'(led_m),   16'(m_led));
        checkOutput({tag, "_time_left"}, 16'(tl_m),    16'd3);
        checkOutput({tag, "_score"},     16'(score_m), 16'd0);
        checkOutput({tag, "_game_over"}, 16'(go_m),    16'd0);
    endtask

    task automatic pushExpect(input logic [3:0] v);
        exp_t e;
        int   inc;
        if (v == m_expected) begin
            inc      = (m_streak >= 1) ? 2 : 1;
            m_score  = (m_score + inc > 15) ? 15 : m_score + inc;
            m_streak = (m_streak + 1 > 2) ? 2 : m_streak + 1;
            e.is_hit = 1'b1;
        end else begin
            m_streak = 0;
            e.is_hit = 1'b0;
        end
        e.score = 4'(m_score);
        sb.push_back(e);
    endtask

    // Waits a bounded number of cycles for the hit/miss pulse, then checks
    // its latency, kind, score and the prompt that follows it
    task automatic awaitResult(input string tag, input int latency);
        int   k;
        bit   seen;
        exp_t e;
        k    = 0;
        seen = 1'b0;
        while (!seen && k < latency + 4) begin
            tick();
            k++;
            if (hit_m || miss_m) seen = 1'b1;
        end
        if (sb.size() > 0) e = sb.pop_front();
        checks++;
        assert (seen) else begin
            errors++;
            $error("[TB] FAIL %s_pulse: observed none expected hit/miss within %0d cycles", tag, latency + 4);
        end
        if (seen) begin
            checkOutput({tag, "_latency"}, 16'(k),       16'(latency));
            checkOutput({tag, "_hit"},     16'(hit_m),   16'(e.is_hit));
            checkOutput({tag, "_miss"},    16'(miss_m),  16'(!e.is_hit));
            checkOutput({tag, "_score"},   16'(score_m), 16'(e.score));
            predictPrompt();
            tick();
            checkOutput({tag, "_next_prompt"}, 16'(led_m), 16'(m_led));
        end
    endtask

    task automatic flipAndCheck(input string tag, input logic [3:0] mask);
        applyStimulus(m_sw[sel] ^ mask);
        pushExpect(m_sw[sel]);
        awaitResult(tag, 6);
    endtask

    task automatic runTo(input int target);
        while (cyc < target) tick();
    endtask

    task automatic checkGameEnd(input string tag);
        int hs_before;
        hs_before = m_high;
        if (m_score > m_high) m_high = m_score;
        runTo(gstart + 30);
        checkOutput({tag, "_still_playing"}, 16'(go_m), 16'd0);
        checkOutput({tag, "_last_second"},   16'(tl_m), 16'd1);
        tick();
        checkOutput({tag, "_game_over"},     16'(go_m),   16'd1);
        checkOutput({tag, "_time_zero"},     16'(tl_m),   16'd0);
        checkOutput({tag, "_leds_all_on"},   16'(led_m),  16'hF);
        checkOutput({tag, "_high_pending"},  16'(high_m), 16'(hs_before));
        tick();
        checkOutput({tag, "_high_score"},    16'(high_m), 16'(m_high));
        checkOutput({tag, "_score_held"},    16'(score_m), 16'(m_score));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed no end of test, expected completion before 100000 time units");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] mask;
        sel    = 0;
        reset  = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        sw0    = 4'h0;
        sw1    = 4'h0;
        m_sw   = '{4'h0, 4'h0};
        m_last = '{0, 0};
        m_high = 0;
        tick(); tick(); tick();
        checkOutput("reset_led",        16'(led_m),   16'h0);
        checkOutput("reset_score",      16'(score_m), 16'h0);
        checkOutput("reset_high",       16'(high_m),  16'h0);
        checkOutput("reset_time_left",  16'(tl_m),    16'd3);
        checkOutput("reset_game_over",  16'(go_m),    16'd0);
        checkOutput("reset_hit_miss",   16'({hit_m, miss_m}), 16'd0);
        reset = 1'b0;
        tick();

        // Game 1: hit, streak-bonus hit, miss, hit after streak reset, timeout
        $display("[TB] game 1: scoring and streak");
        startGame("g1");
        flipAndCheck("g1_hit1", m_led);
        flipAndCheck("g1_hit2", m_led);
        flipAndCheck("g1_miss", {m_led[2:0], m_led[3]});
        flipAndCheck("g1_hit3", m_led);
        checkGameEnd("g1");

        // Game 2: bouncing switch yields one miss, lower score keeps the high score
        $display("[TB] game 2: bounce and retained high score");
        startGame("g2");
        mask = {m_led[2:0], m_led[3]};
        for (int i = 0; i < 5; i++) begin
            applyStimulus(m_sw[sel] ^ mask);
            if (i < 4) begin
                tick();
                checkOutput("g2_bounce_quiet", 16'(hit_m | miss_m), 16'd0);
                tick();
                checkOutput("g2_bounce_quiet", 16'(hit_m | miss_m), 16'd0);
            end
        end
        pushExpect(m_sw[sel]);
        awaitResult("g2_bounce", 6);
        checkGameEnd("g2");

        // Long round: sixteen hits push the score into saturation
        $display("[TB] long round: score saturation");
        sel = 1;
        startGame("sat");
        for (int i = 0; i < 16; i++)
            flipAndCheck($sformatf("sat_hit%0d", i), m_led);

        // Game 3: reset while the switches are settling
        $display("[TB] game 3: reset mid-settle");
        sel = 0;
        startGame("g3");
        applyStimulus(m_sw[sel] ^ m_led);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset  = 1'b0;
        m_last = '{0, 0};
        m_high = 0;
        checkOutput("rst_led",       16'(led_m),   16'h0);
        checkOutput("rst_score",     16'(score_m), 16'h0);
        checkOutput("rst_high",      16'(high_m),  16'h0);
        checkOutput("rst_time_left", 16'(tl_m),    16'd3);
        checkOutput("rst_game_over", 16'(go_m),    16'd0);
        checkOutput("rst_hit_miss",  16'({hit_m, miss_m}), 16'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            checkOutput("rst_idle_quiet", 16'({led_m, hit_m, miss_m}), 16'd0);
        end
        startGame("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
